sftm_patch_feeder: RTL and testbench
====================================

SFTM_PATCH_FEEDER -- requirements
Module: sftm_patch_feeder

Interface
REQ-001 Params SHALL be: DATA_W=16 (pixel width); ADDR_W=12 (feature-map SRAM address width); DIM_W=8 (width/height field width).
REQ-002 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cmd_start  in  1  one-cycle request to stream one feature map; sampled only in IDLE.
REQ-005 cmd_abort  in  1  synchronous flush to IDLE; wins over every other event.
REQ-006 conv_mode  in  1  1=conv (tile stride 2), 0=deconv (tile stride 4); latched at cmd_start.
REQ-007 base_addr  in  ADDR_W  first-pixel address; latched at cmd_start.
REQ-008 fm_width, fm_height  in  DIM_W each  map dimensions in pixels; latched at cmd_start.
REQ-009 mem_rd_en  out  1  SRAM read strobe.
REQ-010 mem_addr  out  ADDR_W  SRAM read address.
REQ-011 mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 input_data  out  DATA_W  serial pixel to the SFTM input stream.
REQ-013 input_valid  out  1  input_data valid; transfer occurs when input_valid && out_ready.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 sftm_start  out  1  high from the cycle after cmd_start acceptance until the cycle of the last transfer.
REQ-016 tile_last  out  1  high with the 16th pixel of each tile.
REQ-017 busy  out  1  high whenever state != IDLE.
REQ-018 done  out  1  one-cycle pulse at stream completion.

Function
REQ-019 States SHALL be IDLE, ISSUE, DRAIN: IDLE->ISSUE on cmd_start with nonzero dims; ISSUE->DRAIN after last pixel request; DRAIN->IDLE after last transfer; done pulses on the DRAIN->IDLE transition.
REQ-020 cmd_start with fm_width==0 or fm_height==0 SHALL produce done the next cycle with no transfers and no reads.
REQ-021 Tile origins SHALL be (ty,tx) = (S*i, S*j), S=2 conv / 4 deconv, for S*i<fm_height, S*j<fm_width; order row-major over tiles.
REQ-022 Each tile SHALL emit 16 pixels row-major (r=0..3, c=0..3) at (ty+r, tx+c).
REQ-023 Pixels with row>=fm_height or col>=fm_width SHALL be emitted as zero without asserting mem_rd_en, through the same 1-cycle slot as real reads.
REQ-024 mem_addr SHALL equal base_addr + row*fm_width + col, mod 2^ADDR_W; row base SHALL be accumulated by adds (no multiplier).
REQ-025 Output SHALL be the head of a 2-entry FIFO; one pixel request issues per cycle only if (fifo_count + in_flight - pop) < 2, so the FIFO never overflows.
REQ-026 With out_ready held high, throughput SHALL be 1 pixel/cycle; first mem_rd_en SHALL occur the cycle after cmd_start is sampled, first input_valid one cycle later.
REQ-027 When input_valid && !out_ready, input_data and tile_last SHALL hold stable.
REQ-028 cmd_start while busy SHALL be ignored; cmd_start and cmd_abort together SHALL abort.
REQ-029 cmd_abort SHALL empty the FIFO, drop the in-flight read's data, clear outputs, return to IDLE without done.

Reset
REQ-030 On rst_n low, all outputs SHALL be 0, state IDLE, FIFO empty, latched params 0, independent of clk.
REQ-031 Reset mid-stream SHALL discard all progress; the first cmd_start after release restarts from tile (0,0).

Structure
REQ-032 State encoding, stride constants (2/4) and tile size (4) SHALL live in the shared SFTM package.
REQ-033 The 2-entry FIFO SHALL be one sub-module, sftm_skid_fifo.

Verification
REQ-034 Conv, 4x4 map, base 0x010, ready=1 -> 4 tiles (origins (0,0),(0,2),(2,0),(2,2)), 64 transfers, tile 0 reads 0x010..0x01F row-major; done once.
REQ-035 Deconv, 6x5 map (W=6,H=5), base 0 -> tiles (0,0),(0,4),(4,0),(4,4); tile (4,4) reads only (4,4),(4,5), 14 zeros; tile_last every 16th transfer.
REQ-036 Conv 4x4, out_ready toggling 1/0 each cycle -> identical 64-value sequence, no drops/duplicates, held values stable during stall.
REQ-037 cmd_abort at transfer 20 of REQ-034 -> busy=0 next cycle, no done; new cmd_start yields full 64-pixel sequence from (0,0).
REQ-038 fm_width=0 -> done next cycle, mem_rd_en never asserted, input_valid never asserted.
REQ-039 base_addr=0xFFE, 4x4 conv -> address wraps to 0x000..; rst_n asserted mid-tile -> all outputs 0 immediately.

Source files
------------

// File: rtl/sftm_patch_feeder_pkg.sv
// rtl/sftm_patch_feeder_pkg.sv - shared SFTM constants and feeder state encoding
// Purpose: tile geometry, stride constants and the feeder FSM state type,
// shared by the patch feeder and its sub-modules.
// Ports: none (package).
package sftm_patch_feeder_pkg;

  // Tiles are TILE_DIM x TILE_DIM pixels, streamed row-major.
  localparam int TILE_DIM = 4;

  // Tile origin stride; conv overlaps tiles by half, deconv tiles abut.
  localparam int STRIDE_CONV      = 2;
  localparam int STRIDE_DECONV    = 4;
  // log2 of the strides, so stride*width is built from a shift, not a multiply.
  localparam int STRIDE_CONV_SH   = 1;
  localparam int STRIDE_DECONV_SH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/sftm_patch_feeder_if.sv
// rtl/sftm_patch_feeder_if.sv - SRAM read port and SFTM pixel stream bundle
// Purpose: groups the feature-map SRAM read port and the serial pixel stream.
// Ports (master = feeder side):
//   mem_rd_en/mem_addr  out  SRAM read strobe and address
//   mem_rdata           in   read data, one cycle after mem_rd_en
//   input_data/input_valid/tile_last  out  pixel stream towards the SFTM
//   out_ready           in   downstream accept
interface sftm_patch_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] input_data;
  logic              input_valid;
  logic              tile_last;
  logic              out_ready;

  modport master (
    output mem_rd_en, mem_addr, input_data, input_valid, tile_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, input_data, input_valid, tile_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/sftm_skid_fifo.sv
// rtl/sftm_skid_fifo.sv - 2-entry fall-through FIFO at the head of the pixel stream
// Purpose: buffers pixels returning from the 1-cycle read slot. When empty, a
// pushed word is presented the same cycle (fall-through); if not accepted it is
// stored, so the presented word stays stable under back-pressure.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop all contents and any word being pushed
//   push, push_data       write strobe and word
//   pop_ready             consumer accept
//   out_valid, out_data   head word (zero data when nothing is presented)
//   count                 number of stored words (0..2)
module sftm_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         empty, do_pop, bypass, wr_en, rd_adv;

  always_comb begin
    empty     = (count_q == 2'd0);
    out_valid = !empty || push;
    out_data  = empty ? push_data : mem_q[rd_ptr_q];
    do_pop    = out_valid && pop_ready;
    // An accepted push into an empty FIFO goes straight through, never stored.
    bypass    = empty && push && do_pop;
    wr_en     = push && !bypass;
    rd_adv    = do_pop && !empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (rd_adv) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, wr_en} - {1'b0, rd_adv};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/sftm_patch_feeder.sv
// rtl/sftm_patch_feeder.sv - streams a feature map as 4x4 tiles into the SFTM
// Purpose: walks tile origins at stride 2 (conv) or 4 (deconv), issues one
// pixel request per cycle (SRAM read, or a zero for pixels outside the map)
// and delivers pixels through a 2-entry FIFO.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_start, cmd_abort       start a map (IDLE only) / flush to IDLE
//   conv_mode, base_addr, fm_width, fm_height  map parameters, latched at start
//   sftm_start, busy, done     stream active, FSM not idle, completion pulse
//   bus                        SRAM read port + pixel stream (master)
module sftm_patch_feeder
  import sftm_patch_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic              conv_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  fm_width,
  input  logic [DIM_W-1:0]  fm_height,
  output logic              sftm_start,
  output logic              busy,
  output logic              done,
  sftm_patch_feeder_if.master bus
);
  // Coordinates need headroom for origin + 3 and origin + stride.
  localparam int CW = DIM_W + 2;

  feeder_state_e     state_q, state_d;
  logic              conv_q, conv_d;
  logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
  logic [CW-1:0]     ty_q, ty_d, tx_q, tx_d;
  logic [1:0]        r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0] tile_row_base_q, tile_row_base_d;  // base + ty*W
  logic [ADDR_W-1:0] pix_row_base_q, pix_row_base_d;    // base + (ty+r)*W
  logic              in_flight_q, in_flight_d;
  logic              in_flight_real_q, in_flight_real_d;
  logic              in_flight_last_q, in_flight_last_d;
  logic              sftm_start_q, sftm_start_d;
  logic              done_q, done_d;

  logic [CW-1:0]     row, col, stride, tx_step, ty_step;
  logic [ADDR_W-1:0] width_a, stride_rows;
  logic              pix_in_map, issue, pop, last_xfer;
  logic [2:0]        occupancy;
  logic [DATA_W:0]   push_data, fifo_data;
  logic              fifo_valid;
  logic [1:0]        fifo_count;

  always_comb begin
    row         = ty_q + CW'(r_q);
    col         = tx_q + CW'(c_q);
    pix_in_map  = (row < {2'b00, height_q}) && (col < {2'b00, width_q});
    stride      = conv_q ? CW'(STRIDE_CONV) : CW'(STRIDE_DECONV);
    tx_step     = tx_q + stride;
    ty_step     = ty_q + stride;
    width_a     = ADDR_W'(width_q);
    stride_rows = conv_q ? (width_a << STRIDE_CONV_SH) : (width_a << STRIDE_DECONV_SH);

    pop       = fifo_valid && bus.out_ready && !cmd_abort;
    // Words stored plus the one returning this cycle, after this cycle's pop.
    occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, pop};
    issue     = (state_q == ST_ISSUE) && !cmd_abort && (occupancy < 3'd2);
    last_xfer = pop && (({1'b0, fifo_count} + {2'b00, in_flight_q}) == 3'd1);
    push_data = {in_flight_last_q, (in_flight_real_q ? bus.mem_rdata : {DATA_W{1'b0}})};
  end

  always_comb begin
    state_d          = state_q;
    conv_d           = conv_q;
    width_d          = width_q;
    height_d         = height_q;
    ty_d             = ty_q;
    tx_d             = tx_q;
    r_d              = r_q;
    c_d              = c_q;
    tile_row_base_d  = tile_row_base_q;
    pix_row_base_d   = pix_row_base_q;
    in_flight_d      = issue;
    in_flight_real_d = issue && pix_in_map;
    in_flight_last_d = issue && (r_q == 2'(TILE_DIM - 1)) && (c_q == 2'(TILE_DIM - 1));
    sftm_start_d     = sftm_start_q;
    done_d           = 1'b0;

    if (cmd_abort) begin
      state_d      = ST_IDLE;
      sftm_start_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_start) begin
          conv_d          = conv_mode;
          width_d         = fm_width;
          height_d        = fm_height;
          ty_d            = '0;
          tx_d            = '0;
          r_d             = 2'd0;
          c_d             = 2'd0;
          tile_row_base_d = base_addr;
          pix_row_base_d  = base_addr;
          if (fm_width == '0 || fm_height == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            sftm_start_d = 1'b1;
          end
        end
        ST_ISSUE: if (issue) begin
          if (c_q != 2'(TILE_DIM - 1)) begin
            c_d = c_q + 2'd1;
          end else if (r_q != 2'(TILE_DIM - 1)) begin
            c_d            = 2'd0;
            r_d            = r_q + 2'd1;
            pix_row_base_d = pix_row_base_q + width_a;
          end else begin
            c_d = 2'd0;
            r_d = 2'd0;
            if (tx_step < {2'b00, width_q}) begin
              tx_d           = tx_step;
              pix_row_base_d = tile_row_base_q;
            end else if (ty_step < {2'b00, height_q}) begin
              tx_d            = '0;
              ty_d            = ty_step;
              tile_row_base_d = tile_row_base_q + stride_rows;
              pix_row_base_d  = tile_row_base_q + stride_rows;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: if (last_xfer) begin
          state_d      = ST_IDLE;
          sftm_start_d = 1'b0;
          done_d       = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      conv_q           <= 1'b0;
      width_q          <= '0;
      height_q         <= '0;
      ty_q             <= '0;
      tx_q             <= '0;
      r_q              <= 2'd0;
      c_q              <= 2'd0;
      tile_row_base_q  <= '0;
      pix_row_base_q   <= '0;
      in_flight_q      <= 1'b0;
      in_flight_real_q <= 1'b0;
      in_flight_last_q <= 1'b0;
      sftm_start_q     <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      conv_q           <= conv_d;
      width_q          <= width_d;
      height_q         <= height_d;
      ty_q             <= ty_d;
      tx_q             <= tx_d;
      r_q              <= r_d;
      c_q              <= c_d;
      tile_row_base_q  <= tile_row_base_d;
      pix_row_base_q   <= pix_row_base_d;
      in_flight_q      <= in_flight_d;
      in_flight_real_q <= in_flight_real_d;
      in_flight_last_q <= in_flight_last_d;
      sftm_start_q     <= sftm_start_d;
      done_q           <= done_d;
    end
  end

  // Abort flushes the in-flight word too: it is pushed during the flush and discarded.
  sftm_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (cmd_abort),
    .push      (in_flight_q),
    .push_data (push_data),
    .pop_ready (bus.out_ready && !cmd_abort),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign bus.mem_rd_en   = issue && pix_in_map;
  assign bus.mem_addr    = (issue && pix_in_map) ? (pix_row_base_q + ADDR_W'(col)) : '0;
  assign bus.input_valid = fifo_valid && !cmd_abort;
  assign bus.input_data  = bus.input_valid ? fifo_data[DATA_W-1:0] : '0;
  assign bus.tile_last   = bus.input_valid && fifo_data[DATA_W];
  assign sftm_start      = sftm_start_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
endmodule

// File: tb/tb_sftm_patch_feeder.sv
// tb/tb_sftm_patch_feeder.sv - scoreboard testbench for sftm_patch_feeder
module tb_sftm_patch_feeder;

  typedef struct packed {
    logic        l;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, cmd_start, cmd_abort, conv_mode;
  logic [11:0] base_addr;
  logic [7:0]  fm_width, fm_height;
  logic        sftm_start, busy, done;

  sftm_patch_feeder_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  sftm_patch_feeder #(.DATA_W(16), .ADDR_W(12), .DIM_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_start  (cmd_start),
    .cmd_abort  (cmd_abort),
    .conv_mode  (conv_mode),
    .base_addr  (base_addr),
    .fm_width   (fm_width),
    .fm_height  (fm_height),
    .sftm_start (sftm_start),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0, n_fail = 0;
  int   xfer_cnt = 0, rd_cnt = 0, done_cnt = 0, valid_cnt = 0, exp_reads = 0;
  int   cyc_now = 0, first_rd = -1, first_valid = -1;
  int   ready_mode = 0;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: tiles row-major, pixels row-major, out-of-map pixels zero.
  task automatic build(input bit conv, input logic [11:0] base, input int w, input int h);
    int s;
    s = conv ? 2 : 4;
    exp_reads = 0;
    for (int ty = 0; ty < h; ty += s)
      for (int tx = 0; tx < w; tx += s)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            exp_t e;
            logic [11:0] a;
            if ((ty + r) < h && (tx + c) < w) begin
              a   = base + 12'((ty + r) * w + tx + c);
              e.d = {4'hA, a};
              exp_reads++;
            end else begin
              e.d = 16'h0000;
            end
            e.l = (r == 3 && c == 3);
            exp_q.push_back(e);
          end
  endtask

  // SRAM model: data = {4'hA, addr}, junk when no read was issued.
  initial begin
    logic        rd;
    logic [11:0] a;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      rd = bus.mem_rd_en;
      a  = bus.mem_addr;
      @(posedge clk);
      #1 bus.mem_rdata = rd ? {4'hA, a} : 16'hDEAD;
    end
  end

  // Downstream ready: held high, or toggling every cycle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) bus.out_ready = ~bus.out_ready;
      else bus.out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each transfer, checks stall stability.
  initial begin
    bit          prev_stall;
    logic [16:0] prev_word;
    exp_t        e;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.mem_rd_en) begin
          rd_cnt++;
          if (first_rd < 0) first_rd = cyc_now;
        end
        if (bus.input_valid) begin
          valid_cnt++;
          if (first_valid < 0) first_valid = cyc_now;
        end
        if (done) done_cnt++;
        if (prev_stall)
          check("stall_hold", {bus.input_valid, bus.tile_last, bus.input_data}, {1'b1, prev_word});
        if (bus.input_valid && bus.out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_xfer: got data 0x%0h with empty scoreboard", bus.input_data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("xfer%0d", xfer_cnt), {bus.tile_last, bus.input_data}, {e.l, e.d});
          end
        end
        prev_stall = bus.input_valid && !bus.out_ready;
        prev_word  = {bus.tile_last, bus.input_data};
      end
    end
  end

  task automatic clear_counts();
    xfer_cnt = 0; rd_cnt = 0; done_cnt = 0; valid_cnt = 0;
    first_rd = -1; first_valid = -1;
  endtask

  task automatic kick(input bit conv, input logic [11:0] base, input int w, input int h);
    conv_mode = conv;
    base_addr = base;
    fm_width  = 8'(w);
    fm_height = 8'(h);
    cmd_start = 1'b1;
  endtask

  // Called at posedge+1; exp_lat < 0 skips the timing checks.
  task automatic run_stream(input string name, input bit conv, input logic [11:0] base,
                            input int w, input int h, input int exp_lat);
    int n_exp, t0, lat;
    bit seen;
    exp_q.delete();
    build(conv, base, w, h);
    n_exp = exp_q.size();
    clear_counts();
    kick(conv, base, w, h);
    t0 = cyc_now;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        seen = 1'b1;
        lat  = cyc_now - t0;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({name, "_done_seen"}, seen, 1);
    if (exp_lat >= 0) begin
      check({name, "_done_latency"}, lat, exp_lat);
      if (n_exp > 0) begin
        check({name, "_first_rd_cycle"}, first_rd - t0, 1);
        check({name, "_first_valid_cycle"}, first_valid - t0, 2);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_sb_left"}, exp_q.size(), 0);
    check({name, "_xfers"}, xfer_cnt, n_exp);
    check({name, "_reads"}, rd_cnt, exp_reads);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; conv_mode = 1'b0;
    base_addr = '0; fm_width = '0; fm_height = '0;
    #1;
    check("reset_outputs_a", {bus.mem_rd_en, bus.mem_addr, bus.input_valid, bus.tile_last}, 0);
    check("reset_outputs_b", {bus.input_data, sftm_start, busy, done}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_stream("conv4x4", 1'b1, 12'h010, 4, 4, 66);
    run_stream("deconv6x5", 1'b0, 12'h000, 6, 5, -1);

    ready_mode = 1;
    run_stream("conv4x4_stall", 1'b1, 12'h010, 4, 4, -1);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Abort after the 20th transfer, then a clean restart.
    exp_q.delete();
    build(1'b1, 12'h010, 4, 4);
    clear_counts();
    kick(1'b1, 12'h010, 4, 4);
    @(posedge clk);
    #1 cmd_start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (xfer_cnt >= 20) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_abort = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 cmd_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_outputs", {sftm_start, bus.input_valid, bus.mem_rd_en}, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_xfers", xfer_cnt, 20);
    run_stream("after_abort", 1'b1, 12'h010, 4, 4, 66);

    run_stream("zero_width", 1'b1, 12'h010, 0, 4, 1);
    check("zero_width_valid", valid_cnt, 0);

    run_stream("wrap", 1'b1, 12'hFFE, 4, 4, 66);

    // Reset asserted mid-tile, away from a clock edge.
    exp_q.delete();
    build(1'b1, 12'h010, 4, 4);
    clear_counts();
    kick(1'b1, 12'h010, 4, 4);
    @(posedge clk);
    #1 cmd_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midreset_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outputs_a", {bus.mem_rd_en, bus.mem_addr, bus.input_valid, bus.tile_last}, 0);
    check("midreset_outputs_b", {bus.input_data, sftm_start, busy, done}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_stream("after_reset", 1'b1, 12'h010, 4, 4, 66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
